// File: rtl/data_mem_lsu.sv
// data_mem_lsu: data memory with load/store unit for the single-issue RISC-V datapath.
// Loads return an aligned, sign/zero-extended result on Memoria one edge after acceptance.
// Misaligned accesses, illegal funct3 codes and simultaneous read+write are rejected with AccessErr.
// Optional build macro LSU_STATS_EN adds LoadCount/StoreCount/ErrCount statistics outputs.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] Memoria,
    output logic        MemValid,
    output logic        AccessErr
`ifdef LSU_STATS_EN
    ,
    output logic [31:0] LoadCount,
    output logic [31:0] StoreCount,
    output logic [15:0] ErrCount
`endif
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        r_memoria;
    logic               r_accessErr;

    logic [IDX_W-1:0]   w_wordIdx;
    logic               w_ldFunctOk;
    logic               w_stFunctOk;
    logic               w_aligned;
    logic               w_loadOk;
    logic               w_storeOk;
    logic               w_err;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_loadData;
    logic               w_unused;

    // Upper address bits only alias; they are deliberately ignored
    assign w_unused  = &{1'b0, Addr[31:IDX_W+2]};
    assign w_wordIdx = Addr[IDX_W+1:2];

    // Request legality: funct3 code, natural alignment and exclusive read/write
    always_comb begin
        w_ldFunctOk = 1'b0;
        w_stFunctOk = 1'b0;
        w_aligned   = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: begin w_ldFunctOk = 1'b1; w_stFunctOk = 1'b1; end
            3'b100, 3'b101:         w_ldFunctOk = 1'b1;
            default:                ;
        endcase
        case (funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~Addr[0];
            2'b10:   w_aligned = (Addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        w_loadOk  = MemRead & ~MemWrite & w_ldFunctOk & w_aligned;
        w_storeOk = MemWrite & ~MemRead & w_stFunctOk & w_aligned;
        w_err     = (MemRead | MemWrite) & ~w_loadOk & ~w_storeOk;
    end

    // Lane selection and sign/zero extension of the addressed word
    always_comb begin
        w_word = r_mem[w_wordIdx];
        case (Addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = Addr[1] ? w_word[31:16] : w_word[15:0];
        case (funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadData = {24'h0, w_byte};
            3'b101:  w_loadData = {16'h0, w_half};
            default: w_loadData = w_word;
        endcase
    end

    // Byte-enabled store into the array; contents are never reset
    always_ff @(posedge clk) begin
        if (w_storeOk) begin
            case (funct3[1:0])
                2'b00: begin
                    case (Addr[1:0])
                        2'b00:   r_mem[w_wordIdx][7:0]   <= WriteData[7:0];
                        2'b01:   r_mem[w_wordIdx][15:8]  <= WriteData[7:0];
                        2'b10:   r_mem[w_wordIdx][23:16] <= WriteData[7:0];
                        default: r_mem[w_wordIdx][31:24] <= WriteData[7:0];
                    endcase
                end
                2'b01: begin
                    if (Addr[1]) r_mem[w_wordIdx][31:16] <= WriteData[15:0];
                    else         r_mem[w_wordIdx][15:0]  <= WriteData[15:0];
                end
                default: r_mem[w_wordIdx] <= WriteData;
            endcase
        end
    end

    // State register plus registered load result and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_memoria   <= 32'h0;
            r_accessErr <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_accessErr <= w_err;
            if (w_loadOk) r_memoria <= w_loadData;
        end
    end

    // Next state: any accepted load leads to RESP, everything else back to IDLE
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE:    if (w_loadOk) w_nextState = RESP;
            RESP:    if (w_loadOk) w_nextState = RESP;
            default: w_nextState = IDLE;
        endcase
    end

    assign Memoria   = r_memoria;
    assign MemValid  = (r_state == RESP);
    assign AccessErr = r_accessErr;

`ifdef LSU_STATS_EN
    logic [31:0] r_loadCount;
    logic [31:0] r_storeCount;
    logic [15:0] r_errCount;

    // Access statistics; the error counter saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadCount  <= 32'h0;
            r_storeCount <= 32'h0;
            r_errCount   <= 16'h0;
        end else begin
            if (w_loadOk)  r_loadCount  <= r_loadCount + 32'd1;
            if (w_storeOk) r_storeCount <= r_storeCount + 32'd1;
            if (w_err && (r_errCount != 16'hFFFF)) r_errCount <= r_errCount + 16'd1;
        end
    end

    assign LoadCount  = r_loadCount;
    assign StoreCount = r_storeCount;
    assign ErrCount   = r_errCount;
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed plus randomized bench for data_mem_lsu against a byte-array reference model.
// Define LSU_STATS_EN to also check the statistics counters.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] Memoria;
    logic        MemValid;
    logic        AccessErr;
`ifdef LSU_STATS_EN
    logic [31:0] LoadCount;
    logic [31:0] StoreCount;
    logic [15:0] ErrCount;
`endif

    int          assertCount = 0;
    int          failCount   = 0;

    // Reference state: flat little-endian byte memory and expected outputs
    logic [7:0]  modMem [4096];
    logic [31:0] expMemoria = 32'h0;
    logic        expValid   = 1'b0;
    logic        expErr     = 1'b0;
    int          expLoads   = 0;
    int          expStores  = 0;
    int          expErrs    = 0;

    data_mem_lsu #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .Memoria   (Memoria),
        .MemValid  (MemValid),
        .AccessErr (AccessErr)
`ifdef LSU_STATS_EN
        ,
        .LoadCount (LoadCount),
        .StoreCount(StoreCount),
        .ErrCount  (ErrCount)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " Memoria"},   Memoria,   expMemoria);
        checkOutput({tag, " MemValid"},  {31'h0, MemValid},  {31'h0, expValid});
        checkOutput({tag, " AccessErr"}, {31'h0, AccessErr}, {31'h0, expErr});
`ifdef LSU_STATS_EN
        checkOutput({tag, " LoadCount"},  LoadCount,  expLoads);
        checkOutput({tag, " StoreCount"}, StoreCount, expStores);
        checkOutput({tag, " ErrCount"},   {16'h0, ErrCount}, expErrs);
`endif
    endtask

    // One request cycle: model predicts, DUT is clocked, outputs compared #1 after the edge
    task automatic applyStimulus(input string tag, input bit rd, input bit wr,
                                 input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          size;
        int          base;
        bit          legalF3;
        bit          aligned;
        logic [31:0] val;
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        Addr      = a;
        WriteData = wd;
        size      = 1 << f3[1:0];
        base      = int'(a[11:0]);
        aligned   = ((int'(a[1:0]) % size) == 0);
        legalF3   = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        expValid  = 1'b0;
        expErr    = 1'b0;
        if (rd || wr) begin
            if ((rd && wr) || !legalF3 || !aligned) begin
                expErr = 1'b1;
                if (expErrs < 65535) expErrs++;
            end else if (rd) begin
                val = 32'h0;
                for (int i = 0; i < size; i++) val = val | (32'(modMem[base + i]) << (8 * i));
                if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | (32'hFFFFFFFF << (8 * size));
                expMemoria = val;
                expValid   = 1'b1;
                expLoads++;
            end else begin
                for (int i = 0; i < size; i++) modMem[base + i] = wd[8 * i +: 8];
                expStores++;
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idleInputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'd0;
        Addr      = 32'h0;
        WriteData = 32'h0;
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any clock edge
    task automatic pulseReset(input string tag);
        idleInputs();
        rst_n = 1'b0;
        expMemoria = 32'h0;
        expValid   = 1'b0;
        expErr     = 1'b0;
        expLoads   = 0;
        expStores  = 0;
        expErrs    = 0;
        #1;
        checkAll(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          kind;
        for (int i = 0; i < 4096; i++) modMem[i] = 8'h0;
        idleInputs();
        rst_n = 1'b1;
        #2;
        pulseReset("reset");

        // Basic store then loads of every width and sign
        applyStimulus("SW 0x10",  0, 1, 3'b010, 32'h10, 32'h8070F0AA);
        applyStimulus("LW 0x10",  1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("LW 0x10 value", Memoria, 32'h8070F0AA);
        applyStimulus("LB 0x10",  1, 0, 3'b000, 32'h10, 32'h0);
        checkOutput("LB 0x10 value", Memoria, 32'hFFFFFFAA);
        applyStimulus("LBU 0x11", 1, 0, 3'b100, 32'h11, 32'h0);
        checkOutput("LBU 0x11 value", Memoria, 32'h000000F0);
        applyStimulus("LH 0x12",  1, 0, 3'b001, 32'h12, 32'h0);
        checkOutput("LH 0x12 value", Memoria, 32'hFFFF8070);
        applyStimulus("LHU 0x12", 1, 0, 3'b101, 32'h12, 32'h0);
        checkOutput("LHU 0x12 value", Memoria, 32'h00008070);
        applyStimulus("idle", 0, 0, 3'b000, 32'h0, 32'h0);

        // Partial stores merge into an existing word
        applyStimulus("SW 0x20", 0, 1, 3'b010, 32'h20, 32'h11111111);
        applyStimulus("SB 0x22", 0, 1, 3'b000, 32'h22, 32'h000000EE);
        applyStimulus("SH 0x20", 0, 1, 3'b001, 32'h20, 32'h0000BEEF);
        applyStimulus("LW 0x20", 1, 0, 3'b010, 32'h20, 32'h0);
        checkOutput("LW 0x20 value", Memoria, 32'h11EEBEEF);

        // Rejected requests
        applyStimulus("LW 0x21 misaligned", 1, 0, 3'b010, 32'h21, 32'h0);
        applyStimulus("LH 0x13 misaligned", 1, 0, 3'b001, 32'h13, 32'h0);
        applyStimulus("load f3=011",        1, 0, 3'b011, 32'h10, 32'h0);
        applyStimulus("read+write",         1, 1, 3'b010, 32'h20, 32'h0);
        applyStimulus("SW 0x22 misaligned", 0, 1, 3'b010, 32'h22, 32'hDEADBEEF);
        applyStimulus("LW 0x20 after err",  1, 0, 3'b010, 32'h20, 32'h0);
        checkOutput("LW 0x20 unchanged", Memoria, 32'h11EEBEEF);

        // Back-to-back loads
        applyStimulus("b2b LW 0x10", 1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("b2b 1 value", Memoria, 32'h8070F0AA);
        applyStimulus("b2b LW 0x20", 1, 0, 3'b010, 32'h20, 32'h0);
        checkOutput("b2b 2 value", Memoria, 32'h11EEBEEF);
        applyStimulus("b2b LW 0x10", 1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("b2b 3 value", Memoria, 32'h8070F0AA);

        // Reset while a load response is pending; array contents survive
        pulseReset("reset in RESP");
        applyStimulus("LW 0x20 post reset", 1, 0, 3'b010, 32'h20, 32'h0);
        checkOutput("LW 0x20 retained", Memoria, 32'h11EEBEEF);
`ifdef LSU_STATS_EN
        checkOutput("LoadCount after reset", LoadCount, 32'd1);
`endif
        applyStimulus("err before reset", 0, 1, 3'b111, 32'h0, 32'h0);
        pulseReset("reset during err");

        // Fill a small window, then randomized traffic with aliased upper bits
        for (int w = 0; w < 16; w++) applyStimulus("init SW", 0, 1, 3'b010, 32'(w * 4), $urandom());
        for (int n = 0; n < 400; n++) begin
            a = $urandom();
            a[11:6] = 6'h0;
            f3 = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            if (kind < 5)       applyStimulus("rand load",  1, 0, f3, a, 32'h0);
            else if (kind < 8)  applyStimulus("rand store", 0, 1, f3, a, $urandom());
            else if (kind == 8) applyStimulus("rand both",  1, 1, f3, a, $urandom());
            else                applyStimulus("rand idle",  0, 0, f3, a, $urandom());
        end
        applyStimulus("final idle", 0, 0, 3'b000, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
